// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel-clock enable, selectable
// sync polarity and a programmable reset position.
module vga_timing_gen #(
    parameter int p_H_ACTIVE  = 640,
    parameter int p_H_FRONT   = 16,
    parameter int p_H_SYNC    = 96,
    parameter int p_H_BACK    = 48,
    parameter int p_V_ACTIVE  = 480,
    parameter int p_V_FRONT   = 10,
    parameter int p_V_SYNC    = 2,
    parameter int p_V_BACK    = 33,
    parameter bit p_HSYNC_POL = 1'b0,
    parameter bit p_VSYNC_POL = 1'b0,
    parameter int p_HPOS      = 0,
    parameter int p_VPOS      = 0,
    parameter int p_CW        = 10
) (
    input  logic            i_Clk,
    input  logic            i_Reset,
    input  logic            i_Enable,
    output logic            o_HSync,
    output logic            o_VSync,
    output logic            o_HBlank,
    output logic            o_VBlank,
    output logic            o_Active,
    output logic [p_CW-1:0] o_HPos,
    output logic [p_CW-1:0] o_VPos,
    output logic            o_HReset,
    output logic            o_VReset
);
    localparam int H_TOTAL = p_H_ACTIVE + p_H_FRONT + p_H_SYNC + p_H_BACK;
    localparam int V_TOTAL = p_V_ACTIVE + p_V_FRONT + p_V_SYNC + p_V_BACK;
    localparam logic [p_CW-1:0] H_LAST   = p_CW'(H_TOTAL - 1);
    localparam logic [p_CW-1:0] V_LAST   = p_CW'(V_TOTAL - 1);
    localparam logic [p_CW-1:0] H_INIT   = p_CW'(p_HPOS);
    localparam logic [p_CW-1:0] V_INIT   = p_CW'(p_VPOS);
    localparam logic [p_CW-1:0] H_ACT    = p_CW'(p_H_ACTIVE);
    localparam logic [p_CW-1:0] V_ACT    = p_CW'(p_V_ACTIVE);
    localparam logic [p_CW-1:0] HS_START = p_CW'(p_H_ACTIVE + p_H_FRONT);
    localparam logic [p_CW-1:0] VS_START = p_CW'(p_V_ACTIVE + p_V_FRONT);
    localparam logic [p_CW-1:0] HS_WIDTH = p_CW'(p_H_SYNC);
    localparam logic [p_CW-1:0] VS_WIDTH = p_CW'(p_V_SYNC);

    logic [p_CW-1:0] h, v, h_off, v_off;
    logic            h_last, v_last, hs_on, vs_on;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            h <= H_INIT;
            v <= V_INIT;
        end else if (i_Enable) begin
            h <= h_last ? '0 : h + 1'b1;
            if (h_last) v <= v_last ? '0 : v + 1'b1;
        end
    end

    assign h_last = (h == H_LAST);
    assign v_last = (v == V_LAST);
    // Offset-from-start compare: positions before the sync window wrap to a value
    // no smaller than the sync width, so the window test never overflows the counter width.
    assign h_off  = h - HS_START;
    assign v_off  = v - VS_START;
    assign hs_on  = (h_off < HS_WIDTH);
    assign vs_on  = (v_off < VS_WIDTH);

    assign o_HSync  = p_HSYNC_POL ? hs_on : ~hs_on;
    assign o_VSync  = p_VSYNC_POL ? vs_on : ~vs_on;
    assign o_HBlank = (h >= H_ACT);
    assign o_VBlank = (v >= V_ACT);
    assign o_Active = ~o_HBlank & ~o_VBlank;
    assign o_HPos   = h;
    assign o_VPos   = v;
    assign o_HReset = i_Enable & h_last;
    assign o_VReset = o_HReset & v_last;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen across four parameterisations
// (offset reset position, default, late-frame start, and active-high syncs).
module tb_vga_timing_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] en  = '0;
    logic [3:0] hs, vs, hb, vb, act, hr, vr;
    logic [9:0] hp [4];
    logic [9:0] vp [4];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // u0: starts at (1,480); u1: defaults; u2: starts at (0,488); u3: as u2 with active-high syncs
    vga_timing_gen #(.p_HPOS(1), .p_VPOS(480)) u0 (
        .i_Clk(clk), .i_Reset(rst), .i_Enable(en[0]),
        .o_HSync(hs[0]), .o_VSync(vs[0]), .o_HBlank(hb[0]), .o_VBlank(vb[0]), .o_Active(act[0]),
        .o_HPos(hp[0]), .o_VPos(vp[0]), .o_HReset(hr[0]), .o_VReset(vr[0]));
    vga_timing_gen u1 (
        .i_Clk(clk), .i_Reset(rst), .i_Enable(en[1]),
        .o_HSync(hs[1]), .o_VSync(vs[1]), .o_HBlank(hb[1]), .o_VBlank(vb[1]), .o_Active(act[1]),
        .o_HPos(hp[1]), .o_VPos(vp[1]), .o_HReset(hr[1]), .o_VReset(vr[1]));
    vga_timing_gen #(.p_VPOS(488)) u2 (
        .i_Clk(clk), .i_Reset(rst), .i_Enable(en[2]),
        .o_HSync(hs[2]), .o_VSync(vs[2]), .o_HBlank(hb[2]), .o_VBlank(vb[2]), .o_Active(act[2]),
        .o_HPos(hp[2]), .o_VPos(vp[2]), .o_HReset(hr[2]), .o_VReset(vr[2]));
    vga_timing_gen #(.p_VPOS(488), .p_HSYNC_POL(1'b1), .p_VSYNC_POL(1'b1)) u3 (
        .i_Clk(clk), .i_Reset(rst), .i_Enable(en[3]),
        .o_HSync(hs[3]), .o_VSync(vs[3]), .o_HBlank(hb[3]), .o_VBlank(vb[3]), .o_Active(act[3]),
        .o_HPos(hp[3]), .o_VPos(vp[3]), .o_HReset(hr[3]), .o_VReset(vr[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hr_cnt;
        logic [9:0] exp_h;
        // reset applies without any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_u0_hpos", hp[0], 1);
        chk("rst_u0_vpos", vp[0], 480);
        chk("rst_u0_vblank", vb[0], 1);
        chk("rst_u0_hblank", hb[0], 0);
        chk("rst_u0_active", act[0], 0);
        chk("rst_u1_hpos", hp[1], 0);
        chk("rst_u1_vpos", vp[1], 0);
        chk("rst_u1_active", act[1], 1);
        chk("rst_u2_vpos", vp[2], 488);
        #9 rst = 1'b0;
        // offset start: 799 ticks from (1,480) land on (0,481)
        en[0] = 1'b1;
        repeat (799) tick();
        chk("t1_hpos", hp[0], 0);
        chk("t1_vpos", vp[0], 481);
        chk("t1_vblank", vb[0], 1);
        chk("t1_active", act[0], 0);
        en[0] = 1'b0;
        // one full default line
        en[1] = 1'b1;
        #1;
        for (int i = 0; i < 800; i++) begin
            chk("t2_hpos", hp[1], i);
            chk("t2_hsync", hs[1], (i >= 656 && i < 752) ? 0 : 1);
            chk("t2_hblank", hb[1], (i >= 640) ? 1 : 0);
            chk("t2_hreset", hr[1], (i == 799) ? 1 : 0);
            chk("t2_vreset", vr[1], 0);
            tick();
        end
        chk("t2_hpos_end", hp[1], 0);
        chk("t2_vpos_end", vp[1], 1);
        en[1] = 1'b0;
        // enable one clock in four over a full line
        hr_cnt = 0;
        exp_h = 10'd0;
        for (int n = 0; n < 800; n++) begin
            en[1] = 1'b1;
            #1;
            hr_cnt += int'(hr[1]);
            chk("t4_hpos_en", hp[1], exp_h);
            tick();
            exp_h = (exp_h == 10'd799) ? 10'd0 : exp_h + 10'd1;
            en[1] = 1'b0;
            #1;
            for (int k = 0; k < 3; k++) begin
                chk("t4_hreset_idle", hr[1], 0);
                chk("t4_hpos_hold", hp[1], exp_h);
                tick();
            end
        end
        chk("t4_hreset_count", hr_cnt, 1);
        chk("t4_vpos", vp[1], 2);
        // late frame through wrap, both sync polarities
        en[2] = 1'b1;
        en[3] = 1'b1;
        #1;
        for (int v = 488; v < 525; v++) begin
            for (int h = 0; h < 800; h++) begin
                if (h == 0) begin
                    chk("t3_vpos", vp[2], v);
                    chk("t3_vsync_lo", vs[2], (v == 490 || v == 491) ? 0 : 1);
                    chk("t6_vsync_hi", vs[3], (v == 490 || v == 491) ? 1 : 0);
                    chk("t3_vblank", vb[2], 1);
                end
                if (v == 488) chk("t6_hsync_hi", hs[3], (h >= 656 && h < 752) ? 1 : 0);
                if (h == 799) chk("t3_hreset", hr[2], 1);
                chk("t3_vreset", vr[2], (v == 524 && h == 799) ? 1 : 0);
                tick();
            end
        end
        chk("t3_wrap_hpos", hp[2], 0);
        chk("t3_wrap_vpos", vp[2], 0);
        chk("t3_wrap_active", act[2], 1);
        chk("t3_wrap_vreset", vr[2], 0);
        chk("t6_wrap_vsync", vs[3], 0);
        en[2] = 1'b0;
        en[3] = 1'b0;
        // asynchronous reset mid-line at h=300, v=2, held with enable high
        en[1] = 1'b1;
        repeat (300) tick();
        chk("t5_pre_hpos", hp[1], 300);
        chk("t5_pre_vpos", vp[1], 2);
        #2 rst = 1'b1;
        #1;
        chk("t5_hpos", hp[1], 0);
        chk("t5_vpos", vp[1], 0);
        chk("t5_hblank", hb[1], 0);
        chk("t5_u0_hpos", hp[0], 1);
        repeat (3) tick();
        chk("t5_hold_hpos", hp[1], 0);
        chk("t5_hold_vpos", vp[1], 0);
        rst = 1'b0;
        tick();
        chk("t5_first_tick", hp[1], 1);
        chk("t5_first_vpos", vp[1], 0);
        en[1] = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
